lsu_dpi_port: RTL



---
 rtl/lsu_dpi_port.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_dpi_port.sv
// lsu_dpi_port: handshaked load/store port from the memory stage onto the npc_read/npc_write memory bus.
// Latency: LAT cycles from accept to resp_valid for aligned accesses, 1 cycle for misaligned/illegal ones.
// Backpressure: one request outstanding; req_ready stays low until the response handshakes on resp_ready.
// Optional trace: define LSU_DPI_TRACE_EN to print one line per memory access and per errored request.
//
// The memory side is exposed as the mem_* group; the simulation harness binds it to npc_read/npc_write.
// mem_ren/mem_wen are high for exactly one cycle and the call takes effect on the edge closing that cycle.

module lsu_dpi_port #(
    parameter int          XLEN     = 64,
    parameter int          LAT      = 2,
    parameter logic [63:0] RST_ADDR = 64'h80000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wen,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [63:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [63:0]     err_addr,
    output logic            mem_ren,
    output logic            mem_wen,
    output logic [63:0]     mem_addr,
    output logic [7:0]      mem_wmask,
    output logic [63:0]     mem_wdata,
    input  logic [63:0]     mem_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wen_q, wen_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [63:0]       addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [63:0]       err_addr_q, err_addr_d;

    logic              req_bad;
    logic              access;
    logic [5:0]        lane_sh;
    logic [7:0]        byte_en;
    logic [63:0]       wdata64;
    logic [63:0]       rd_sh;
    logic [63:0]       ld64;

    // Classify the incoming request: misaligned for its size, or a dword on a 32-bit port.
    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            2'd0: req_bad = 1'b0;
            2'd1: req_bad = req_addr[0];
            2'd2: req_bad = |req_addr[1:0];
            default: req_bad = (|req_addr[2:0]) || (XLEN == 32);
        endcase
    end

    // Memory bus: parked at RST_ADDR with no mask except in the single access cycle.
    always_comb begin
        access  = (state_q == WAIT) && (cnt_q == 4'd0);
        lane_sh = {addr_q[2:0], 3'b000};
        case (size_q)
            2'd0:    byte_en = 8'h01;
            2'd1:    byte_en = 8'h03;
            2'd2:    byte_en = 8'h0F;
            default: byte_en = 8'hFF;
        endcase
        wdata64               = '0;
        wdata64[XLEN-1:0]     = wdata_q;
        mem_ren   = access & ~wen_q;
        mem_wen   = access & wen_q;
        mem_addr  = access ? {addr_q[63:3], 3'b000} : RST_ADDR;
        mem_wmask = mem_wen ? (byte_en << addr_q[2:0]) : 8'h00;
        mem_wdata = mem_wen ? (wdata64 << lane_sh) : 64'd0;
    end

    // Load alignment: bring the addressed lane down to bit 0, then sign/zero extend by size.
    always_comb begin
        rd_sh = mem_rdata >> lane_sh;
        case (size_q)
            2'd0:    ld64 = {{56{sgn_q & rd_sh[7]}},  rd_sh[7:0]};
            2'd1:    ld64 = {{48{sgn_q & rd_sh[15]}}, rd_sh[15:0]};
            2'd2:    ld64 = {{32{sgn_q & rd_sh[31]}}, rd_sh[31:0]};
            default: ld64 = rd_sh;
        endcase
    end

    // Next-state and next-output computation for the IDLE/WAIT/RESP controller.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wen_d        = wen_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        err_addr_d   = err_addr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (req_bad) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                        err_addr_d   = req_addr;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LAT - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = wen_q ? '0 : ld64[XLEN-1:0];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state and registered response; reset abandons any pending access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            wen_q        <= 1'b0;
            size_q       <= 2'd0;
            sgn_q        <= 1'b0;
            addr_q       <= 64'd0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            err_addr_q   <= 64'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wen_q        <= wen_d;
            size_q       <= size_d;
            sgn_q        <= sgn_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign err_addr   = err_addr_q;

`ifdef LSU_DPI_TRACE_EN
    // Trace one line per memory access and per errored request.
    always @(posedge clk) begin
        if (rst_n && access)
            $display("LSU %s addr=%h mask=%h data=%h", wen_q ? "W" : "R", mem_addr,
                     wen_q ? mem_wmask : (byte_en << addr_q[2:0]), wen_q ? mem_wdata : mem_rdata);
        if (rst_n && (state_q == IDLE) && req_valid && req_bad)
            $display("LSU ERR addr=%h size=%0d", req_addr, req_size);
    end
`endif

endmodule
